// File: rtl/ring_counter_pkg.sv
// Shared constants and helpers for the one-hot ring counter.
// The same helpers are used by the RTL and by the one-hot checker.
package ring_counter_pkg;

  localparam int RING_DEFAULT_WIDTH = 4;
  localparam int RING_MAX_WIDTH     = 32;

  // Default reset pattern: only bit 0 set.
  function automatic logic [31:0] onehot_init(input int width);
    return (width > 0) ? 32'd1 : 32'd0;
  endfunction

  // A vector is one-hot when it is non-zero and has no second bit set.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/ring_onehot_check.sv
// Combinational lockout detector for the ring state.
// Flags zero-hot or multi-hot patterns so the ring reloads INIT.
module ring_onehot_check
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = RING_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] vec,
  output logic             recover
);

  // Recovery select: high for any pattern that is not exactly one-hot.
  always_comb begin
    recover = !is_onehot(32'(vec));
  end

endmodule

// File: rtl/ring_counter_4bit.sv
// Free-running one-hot ring counter (rotating phase strobe).
// Illegal states self-heal to INIT on the next clock edge.
module ring_counter_4bit
  import ring_counter_pkg::*;
#(
  parameter int               WIDTH       = RING_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] INIT        = WIDTH'(onehot_init(WIDTH)),
  parameter bit               ROTATE_LEFT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count
);

  if (WIDTH < 2) begin : g_bad_width_lo
    $fatal(1, "ring_counter_4bit: WIDTH must be at least 2");
  end

  if (WIDTH > RING_MAX_WIDTH) begin : g_bad_width_hi
    $fatal(1, "ring_counter_4bit: WIDTH must be at most 32");
  end

  if (!is_onehot(32'(INIT))) begin : g_bad_init
    $fatal(1, "ring_counter_4bit: INIT must be one-hot");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] rot;
  logic             recover;

  ring_onehot_check #(
    .WIDTH (WIDTH)
  ) u_chk (
    .vec     (count_q),
    .recover (recover)
  );

  // Rotation direction is fixed at elaboration time.
  if (ROTATE_LEFT) begin : g_rot_left
    always_comb begin
      rot = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
    end
  end else begin : g_rot_right
    always_comb begin
      rot = {count_q[0], count_q[WIDTH-1:1]};
    end
  end

  // Ring state: async load on reset, reload on lockout, else rotate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= INIT;
    end else if (recover) begin
      count_q <= INIT;
    end else begin
      count_q <= rot;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_ring_counter_4bit.sv
// Bench for ring_counter_4bit: left/right 4-bit and left 6-bit rings.
// Phase-index reference model, vector table and random reset/upsets.
module tb_ring_counter_4bit;

  logic       clk;
  logic       reset;
  logic [3:0] c0;
  logic [3:0] c1;
  logic [5:0] c6;
  logic [3:0] forcev;

  int npass;
  int ntot;
  int p;
  int p0;
  bit corrupt0;

  typedef struct {
    bit         rst;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[15];

  ring_counter_4bit #(.WIDTH(4), .ROTATE_LEFT(1'b1)) u0 (
    .clk   (clk),
    .reset (reset),
    .count (c0)
  );

  ring_counter_4bit #(.WIDTH(4), .ROTATE_LEFT(1'b0)) u1 (
    .clk   (clk),
    .reset (reset),
    .count (c1)
  );

  ring_counter_4bit #(.WIDTH(6), .ROTATE_LEFT(1'b1)) u6 (
    .clk   (clk),
    .reset (reset),
    .count (c6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need $finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ring_exp(input int ph, input int w, input bit left);
    int k;
    k = ph % w;
    if (!left) k = (w - k) % w;
    return 32'd1 << k;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, need %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chk_async_init();
    chk("async_init_l4", 32'(c0), 32'h1);
    chk("async_init_r4", 32'(c1), 32'h1);
    chk("async_init_l6", 32'(c6), 32'h1);
  endtask

  // Called in the low clock phase; applies reset level, checks after edge.
  task automatic step(input bit rst);
    if (!rst) begin
      reset = 1'b0;
      #1;
      p = 0;
      p0 = 0;
      corrupt0 = 1'b0;
      chk_async_init();
    end else begin
      reset = 1'b1;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      p++;
      if (corrupt0) p0 = 0;
      else p0++;
      corrupt0 = 1'b0;
    end
    chk("model_l4", 32'(c0), ring_exp(p0, 4, 1'b1));
    chk("model_r4", 32'(c1), ring_exp(p, 4, 1'b0));
    chk("model_l6", 32'(c6), ring_exp(p, 6, 1'b1));
    chk("onehot_l6", 32'($countones(c6)), 32'd1);
    @(negedge clk);
  endtask

  task automatic upset(input logic [3:0] v);
    #1;
    forcev = v;
    force u0.count_q = forcev;
    #1;
    release u0.count_q;
    #1;
    chk("upset_seen", 32'(c0), 32'(v));
    corrupt0 = 1'b1;
  endtask

  task automatic mid_reset();
    reset = 1'b0;
    #1;
    chk_async_init();
    p = 0;
    p0 = 0;
    corrupt0 = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    npass = 0;
    ntot = 0;
    p = 0;
    p0 = 0;
    corrupt0 = 1'b0;
    forcev = 4'h0;
    reset = 1'b1;

    for (int i = 0; i < 5; i++) tbl[i] = '{1'b0, 4'b0001};
    tbl[5]  = '{1'b1, 4'b0010};
    tbl[6]  = '{1'b1, 4'b0100};
    tbl[7]  = '{1'b1, 4'b1000};
    tbl[8]  = '{1'b1, 4'b0001};
    tbl[9]  = '{1'b1, 4'b0010};
    tbl[10] = '{1'b1, 4'b0100};
    tbl[11] = '{1'b1, 4'b1000};
    tbl[12] = '{1'b1, 4'b0001};
    tbl[13] = '{1'b1, 4'b0010};
    tbl[14] = '{1'b1, 4'b0100};

    #1;
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst);
      chk($sformatf("table_%0d", i), 32'(c0), 32'(tbl[i].exp));
    end

    chk("mid_pre", 32'(c0), 32'h4);
    mid_reset();
    step(1'b1);
    chk("mid_release", 32'(c0), 32'h2);

    upset(4'b0000);
    step(1'b1);
    chk("lock_zero_rec", 32'(c0), 32'h1);
    step(1'b1);
    chk("lock_zero_next", 32'(c0), 32'h2);

    upset(4'b1010);
    step(1'b1);
    chk("lock_multi_rec", 32'(c0), 32'h1);
    step(1'b1);
    chk("lock_multi_next", 32'(c0), 32'h2);

    step(1'b0);
    for (int i = 0; i < 6; i++) step(1'b1);
    chk("w6_wrap", 32'(c6), 32'h1);
    chk("r4_after6", 32'(c1), 32'h4);

    for (int i = 0; i < 400; i++) begin
      int r;
      logic [3:0] v;
      r = int'($urandom_range(0, 99));
      if (r < 6) begin
        mid_reset();
        step(1'b1);
      end else if (r < 10) begin
        step(1'b0);
      end else if (r < 18) begin
        v = 4'($urandom_range(0, 15));
        while ($countones(v) == 1) v = 4'($urandom_range(0, 15));
        upset(v);
        step(1'b1);
      end else begin
        step(1'b1);
      end
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
